// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, FSM state encoding and parity helper
package ps2_pkg;
    localparam int PS2_DATA_BITS      = 8;
    localparam int PS2_FRAME_BITS     = 11;
    localparam int PS2_FILTER_LEN_DEF = 8;
    localparam int PS2_TIMEOUT_DEF    = 20000;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_e;

    // Odd parity: the data bits plus the parity bit must hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction
endpackage

// File: rtl/ps2_frame_receiver_if.sv
// ps2_frame_receiver_if: raw PS/2 lines plus decoded byte outputs
interface ps2_frame_receiver_if;
    import ps2_pkg::*;
    logic                     PS2_CLK;
    logic                     PS2_DAT;
    logic [PS2_DATA_BITS-1:0] Scan_code;
    logic                     Code_valid;
    logic                     Frame_error;
    logic                     Busy;

    modport master (output PS2_CLK, PS2_DAT, input Scan_code, Code_valid, Frame_error, Busy);
    modport slave  (input PS2_CLK, PS2_DAT, output Scan_code, Code_valid, Frame_error, Busy);
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronises a raw line, debounces it and strobes on filtered falls
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
    input  logic Clock_100MHz,
    input  logic Reset_n,
    input  logic line_in,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q, sync_d;
    logic          filt_q, filt_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flip;

    // Level changes only once FILTER_LEN consecutive samples disagree with it
    always_comb begin
        sync_d = {sync_q[0], line_in};
        flip   = (sync_q[1] != filt_q) && (cnt_q == CW'(FILTER_LEN - 1));
        cnt_d  = (sync_q[1] == filt_q || flip) ? '0 : cnt_q + CW'(1);
        filt_d = flip ? sync_q[1] : filt_q;
        fall_d = flip & filt_q;
    end

    // Synchroniser and filter state idle high, like the PS/2 line
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= fall_d;
        end
    end

    assign fall = fall_q;
endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: captures 11-bit PS/2 frames and emits checked scan codes
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEF
) (
    input  logic                Clock_100MHz,
    input  logic                Reset_n,
    ps2_frame_receiver_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(PS2_FRAME_BITS);

    ps2_state_e               state_q, state_d;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic [PS2_DATA_BITS-1:0] scan_q, scan_d;
    logic                     parity_q, parity_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic [1:0]               dat_sync_q, dat_sync_d;
    logic                     fall, dat, tmo_hit;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .Clock_100MHz (Clock_100MHz),
        .Reset_n      (Reset_n),
        .line_in      (bus.PS2_CLK),
        .fall         (fall)
    );

    assign dat     = dat_sync_q[1];
    assign tmo_hit = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));

    // State register
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: a timeout wins over a coincident fall
    always_comb begin
        state_d = state_q;
        if (tmo_hit)
            state_d = ST_IDLE;
        else if (fall)
            case (state_q)
                ST_IDLE:   state_d = dat ? ST_IDLE : ST_DATA;
                ST_DATA:   state_d = (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) ? ST_PARITY : ST_DATA;
                ST_PARITY: state_d = ST_STOP;
                default:   state_d = ST_IDLE;
            endcase
    end

    // Datapath and registered output pulses for each state
    always_comb begin
        dat_sync_d = {dat_sync_q[0], bus.PS2_DAT};
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        scan_d     = scan_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        tmo_d      = (state_q == ST_IDLE || fall || tmo_hit) ? '0 :
                     (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
        if (tmo_hit)
            err_d = 1'b1;
        else if (fall)
            case (state_q)
                ST_IDLE:   bit_cnt_d = '0;
                ST_DATA: begin
                    shift_d   = {dat, shift_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
                ST_PARITY: parity_d = dat;
                default: begin
                    valid_d = dat & odd_parity_ok(shift_q, parity_q);
                    err_d   = ~valid_d;
                    scan_d  = valid_d ? shift_q : scan_q;
                end
            endcase
    end

    // Datapath registers
    always_ff @(posedge Clock_100MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            dat_sync_q <= 2'b11;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            scan_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            dat_sync_q <= dat_sync_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            scan_q     <= scan_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.Scan_code   = scan_q;
    assign bus.Code_valid  = valid_q;
    assign bus.Frame_error = err_q;
    assign bus.Busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// tb_ps2_frame_receiver: table, hand-written and random PS/2 frames against a reference model
module tb_ps2_frame_receiver;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TMO  = 300;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   nvalid = 0;
    int   nerr = 0;
    int   valid_cyc = 0;
    int   stop_fall_cyc = 0;
    bit   pv = 1'b0;
    bit   pe = 1'b0;
    logic [7:0] model_code;

    ps2_frame_receiver_if bus ();

    ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock_100MHz (clk),
        .Reset_n      (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse monitor: counts pulses, checks single-cycle width and mutual exclusion
    always @(negedge clk) begin
        if (bus.Code_valid) begin
            nvalid++;
            valid_cyc = cyc;
        end
        if (bus.Frame_error) nerr++;
        if (bus.Code_valid || bus.Frame_error) chk("valid_err_exclusive", int'(bus.Code_valid && bus.Frame_error), 0);
        if (pv) chk("valid_width", int'(bus.Code_valid), 0);
        if (pe) chk("error_width", int'(bus.Frame_error), 0);
        pv = bus.Code_valid;
        pe = bus.Frame_error;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [PS2_FRAME_BITS-1:0] fr, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            bus.PS2_DAT = fr[i];
            wait_n(10);
            bus.PS2_CLK = 1'b0;
            if (i == PS2_FRAME_BITS - 1) stop_fall_cyc = cyc;
            wait_n(HALF);
            bus.PS2_CLK = 1'b1;
            if (i == glitch_at) begin
                wait_n(10);
                bus.PS2_CLK = 1'b0;
                wait_n(5);
                bus.PS2_CLK = 1'b1;
                wait_n(15);
            end else
                wait_n(HALF - 10);
        end
        bus.PS2_DAT = 1'b1;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic par, input logic stop,
                             input int glitch_at, input bit exp_valid, input logic [7:0] exp_code);
        int n0, e0;
        n0 = nvalid;
        e0 = nerr;
        send_bits({stop, par, d, 1'b0}, PS2_FRAME_BITS, glitch_at);
        wait_n(5);
        chk({tag, "_valid_pulses"}, nvalid - n0, int'(exp_valid));
        chk({tag, "_error_pulses"}, nerr - e0, int'(!exp_valid));
        chk({tag, "_scan_code"}, int'(bus.Scan_code), int'(exp_code));
        chk({tag, "_busy_after"}, int'(bus.Busy), 0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        bit         exp_valid;
        logic [7:0] exp_code;
    } vec_t;

    vec_t tv[8];

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, e0, lat;
        logic [7:0] d;
        logic par, stop;
        bit good;

        tv[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C};
        tv[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h1C};
        tv[2] = '{8'hF0, 1'b1, 1'b0, 1'b0, 8'h1C};
        tv[3] = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0};
        tv[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
        tv[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};
        tv[6] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'hFF};
        tv[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80};

        rst_n = 1'b0;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        wait_n(3);
        chk("reset_scan_code", int'(bus.Scan_code), 0);
        chk("reset_code_valid", int'(bus.Code_valid), 0);
        chk("reset_frame_error", int'(bus.Frame_error), 0);
        chk("reset_busy", int'(bus.Busy), 0);
        rst_n = 1'b1;
        wait_n(20);

        foreach (tv[k]) begin
            run_frame($sformatf("vec%0d", k), tv[k].d, tv[k].par, tv[k].stop, -1, tv[k].exp_valid, tv[k].exp_code);
            if (k == 0) begin
                lat = valid_cyc - stop_fall_cyc;
                total++;
                if (lat < FL + 2 || lat > FL + 4) begin
                    bad++;
                    $display("FAIL latency got=%0d exp=%0d..%0d", lat, FL + 2, FL + 4);
                end
            end
        end
        model_code = 8'h80;

        run_frame("glitch", 8'h1C, 1'b0, 1'b1, 4, 1'b1, 8'h1C);
        model_code = 8'h1C;

        n0 = nvalid;
        e0 = nerr;
        send_bits({1'b1, 1'b1, 8'h33, 1'b0}, 6, -1);
        chk("timeout_busy_mid", int'(bus.Busy), 1);
        wait_n(TMO + 10);
        chk("timeout_error_pulses", nerr - e0, 1);
        chk("timeout_valid_pulses", nvalid - n0, 0);
        chk("timeout_busy_after", int'(bus.Busy), 0);
        chk("timeout_scan_hold", int'(bus.Scan_code), int'(model_code));
        run_frame("after_timeout", 8'h5A, 1'b1, 1'b1, -1, 1'b1, 8'h5A);
        model_code = 8'h5A;

        n0 = nvalid;
        e0 = nerr;
        send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 10, -1);
        chk("rst_mid_busy_before", int'(bus.Busy), 1);
        rst_n = 1'b0;
        wait_n(2);
        chk("rst_mid_scan_in_reset", int'(bus.Scan_code), 0);
        chk("rst_mid_busy_in_reset", int'(bus.Busy), 0);
        rst_n = 1'b1;
        wait_n(30);
        chk("rst_mid_valid_pulses", nvalid - n0, 0);
        chk("rst_mid_error_pulses", nerr - e0, 0);
        chk("rst_mid_scan_after", int'(bus.Scan_code), 0);
        chk("rst_mid_busy_after", int'(bus.Busy), 0);
        model_code = 8'h00;
        run_frame("after_reset", 8'h1C, 1'b0, 1'b1, -1, 1'b1, 8'h1C);
        model_code = 8'h1C;

        for (int r = 0; r < 16; r++) begin
            d    = 8'($urandom);
            par  = ~^d ^ ($urandom_range(0, 3) == 0);
            stop = $urandom_range(0, 3) != 0;
            good = stop && ($countones({d, par}) % 2 == 1);
            if (good) model_code = d;
            run_frame($sformatf("rand%0d", r), d, par, stop, -1, good, model_code);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_frame_receiver.md
# ps2_frame_receiver

Receives raw PS/2 device-to-host frames on `PS2_CLK`/`PS2_DAT` and delivers validated 8-bit scan codes into the `Clock_100MHz` domain. Its output is a one-cycle valid pulse per byte. It sits directly upstream of the keyboard decoder (break/shift/caps handling and ASCII mapping). It owns these functions:
- line synchronisation;
- clock glitch filtering;
- 11-bit frame capture;
- start, parity and stop checking;
- inter-bit timeout recovery.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 20000: maximum gap between PS/2 clock falls inside a frame (200 us at 100 MHz).

Ports:
- `Clock_100MHz`  in  1: system clock. This is the only clock in the block.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `PS2_CLK`  in  1: raw PS/2 clock, asynchronous to `Clock_100MHz`, idle high.
- `PS2_DAT`  in  1: raw PS/2 data, asynchronous, idle high.
- `Scan_code`  out  8: last successfully received byte. It holds its value until the next good frame.
- `Code_valid`  out  1: one-cycle pulse, asserted when `Scan_code` is updated.
- `Frame_error`  out  1: one-cycle pulse on a parity error, a stop-bit error or a timeout.
- `Busy`  out  1: high while a frame is in progress (state not IDLE).

## Operation
- **Input synchronisation:** both inputs pass through 2-flop synchronisers. Synchroniser flops reset to 1.
- **Clock filter:** the filtered clock resets to 1. It changes to a new level only after `FILTER_LEN` consecutive synchronised samples at that level. Any shorter pulse is ignored.
- **Sample event:** a falling edge of the filtered clock produces a one-cycle `fall` strobe. Data is sampled from the synchronised `PS2_DAT` on the `fall` cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), clear the bit counter and go to DATA. On `fall` with data=1, stay in IDLE and raise no error.
  - DATA: on each `fall`, shift the data bit in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store the parity bit and go to STOP. The parity check is odd: XOR of the 8 data bits and the parity bit must equal 1.
  - STOP: on `fall`, if stop=1 and parity is good, load `Scan_code` and pulse `Code_valid`. Otherwise pulse `Frame_error` and leave `Scan_code` unchanged. In both cases return to IDLE.
- **Timeout:**
  - A counter runs in every state except IDLE. It clears on each `fall`.
  - When it reaches `TIMEOUT_CYCLES`, pulse `Frame_error`, discard the partial byte and go to IDLE.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`. The counter saturates and never wraps.
- **Mutual exclusion:** `Code_valid` and `Frame_error` are never high in the same cycle.
- **Simultaneous events:** a `fall` arriving in the same cycle that the timeout is reached is treated as a timeout. That `fall` is not consumed as a start bit.
- **Host-to-device traffic:** not supported. `PS2_CLK` and `PS2_DAT` are inputs only.

## Timing
- **Reset values:**
  - outputs: `Scan_code`=8'h00, `Code_valid`=0, `Frame_error`=0, `Busy`=0;
  - internal: FSM=IDLE, counters=0.
- **Reset mid-frame:** asserting reset during a frame aborts it immediately. No pulse is produced. The next complete frame is decoded normally.
- **Latency:** from the `PS2_CLK` falling edge of the stop bit to `Code_valid` high is `FILTER_LEN`+3 cycles, with ±1 cycle of input-phase uncertainty.
- **Output timing:** `Code_valid` and `Frame_error` are registered and each lasts exactly one cycle.
- **Consumer timing:** `Scan_code` is stable from the `Code_valid` cycle onwards.
- **Busy:** rises one cycle after the start-bit `fall`. It falls in the same cycle that `Code_valid` or `Frame_error` is asserted.
- **Throughput:** back-to-back frames at the 16.7 kHz maximum PS/2 clock are handled without loss. No buffering is needed: one byte takes ≥600 us, while the consumer needs only 1 cycle.

## Structure
- **Shared package `ps2_pkg`:** holds the following, shared with the downstream keyboard decoder:
  - FSM state encoding;
  - `PS2_DATA_BITS`=8;
  - `PS2_FRAME_BITS`=11;
  - default values of `FILTER_LEN` and `TIMEOUT_CYCLES`.
- **Sub-module `ps2_line_filter`:** 2-flop synchroniser, `FILTER_LEN` stability counter and falling-edge strobe. It is instantiated on `PS2_CLK`. `PS2_DAT` uses only a plain 2-flop synchroniser.
- **Top of the block:** the FSM, shift register, bit counter, parity and timeout logic.

## Test plan
- **Clean frame:** 0x1C (start 0, data LSB-first 0,0,1,1,1,0,0,0, parity 0, stop 1, 12 kHz clock) -> `Code_valid` single pulse, `Scan_code`=0x1C, `Busy` low afterwards.
- **Bad parity:** 0x1C sent with parity 1 -> `Frame_error` single pulse, `Code_valid` stays 0, `Scan_code` holds its previous value.
- **Stop-bit error:** 0xF0 (parity 1) sent with stop=0 -> `Frame_error` pulse. A following correct 0xF0 frame -> `Scan_code`=0xF0.
- **Glitch rejection:** 5-cycle low glitch on `PS2_CLK` in mid-DATA, with `FILTER_LEN`=8 -> no extra bit captured, and 0x1C is decoded correctly.
- **Timeout:** clock stops after 5 data bits and the bench waits `TIMEOUT_CYCLES`+10 -> one `Frame_error` pulse and `Busy`=0. A next frame of 0x5A -> `Scan_code`=0x5A.
- **Reset mid-frame:** `Reset_n` pulsed low during the parity bit -> all outputs return to reset values with no pulse. The next 0x1C frame decodes correctly.
